collectible_event_scheduler: RTL and testbench
==============================================

# collectible_event_scheduler

Arbitrates collectible pickup events from several sprite/collision detectors and feeds them, one at a time and rate-limited, to the energy-level block's `collectible_type` input. Buffers bursts in a small FIFO and discards effects the energy block would ignore (power-up while one is active, curse during power-up), counting the drops. Also provides the registered `energy_en` so energy-block enable and effect pulses stay cycle-aligned.

## Interface
- `N_REQ`, 4: number of requesting detectors (2..8)
- `FIFO_DEPTH`, 4: event queue depth (power of 2)
- `GAP_CYCLES`, 2: idle cycles forced after each issued effect (≥1)
- `clk`  in  1  system clock
- `reset_n`  in  1  reset; one clock, asynchronous and active-low
- `tick_en`  in  1  game-run enable
- `req`  in  N_REQ  per-requester pickup request, level, held until acked
- `req_type`  in  3*N_REQ  requester i type at bits [3i+2:3i], stable while `req[i]`
- `ack`  out  N_REQ  one-cycle grant pulse, registered
- `power_up_active`  in  1  status from energy block
- `curse_active`  in  1  status from energy block
- `collectible_type`  out  3  effect code to energy block, non-zero for exactly one cycle per effect
- `energy_en`  out  1  registered `tick_en`
- `fifo_full`  out  1  queue full
- `busy`  out  1  queue non-empty or FSM not IDLE
- `dropped_count`  out  8  saturating count of discarded events

## Operation
- Codes: 2 CURSE, 3 HEART, 4 POWERUP; all others invalid.
- Arbitration (every cycle, independent of `tick_en`): round-robin over `req` masked by current `ack`; search starts at `rr_ptr`; grant only if queue not full at cycle start. On grant: `ack[w]` next cycle, `rr_ptr <= w+1` (mod N_REQ). Full: no grant, requests wait.
- Granted valid type pushed to FIFO; invalid type acked, not pushed, `dropped_count`++.
- FSM IDLE/GAP:
  - IDLE, `tick_en`=1, queue non-empty: pop head. Discard (drop++, stay IDLE) if POWERUP with `power_up_active`=1, or CURSE with `power_up_active`=1. Otherwise register head onto `collectible_type`, load gap counter with GAP_CYCLES, go GAP.
  - GAP: `collectible_type`=0; decrement; at 0 -> IDLE.
  - `tick_en`=0: no pops; GAP counter frozen.
- HEART never filtered. CURSE while `curse_active`=1 issued (energy block ignores, spec keeps it simple).
- Same-cycle push and pop allowed; occupancy unchanged.
- `dropped_count` saturates at 255; two drops in one cycle (invalid grant + filtered pop) add 2.

## Timing
- Reset values: `ack`=0, `collectible_type`=0, `energy_en`=0, `fifo_full`=0, `busy`=0, `dropped_count`=0, `rr_ptr`=0, FIFO empty, state IDLE.
- `req` first seen cycle t -> `ack` t+1, entry visible t+1 -> popped t+1 -> `collectible_type` t+2 (empty queue, IDLE, `tick_en`=1).
- Issue spacing: one effect every GAP_CYCLES+1 cycles minimum.
- Filter uses `power_up_active` sampled at the pop cycle.
- `energy_en` = `tick_en` delayed 1 cycle.
- Reset assertion mid-operation: all state cleared asynchronously, in-flight pulse aborted, queue flushed.

## Structure
- Package `collectible_pkg`: type codes, `TYPE_W`=3, `is_valid_type` function.
- Sub-module `collectible_fifo` (sync, DEPTH param, push/pop/full/empty, pointer wrap with extra MSB). Arbiter, filter, FSM in top.

## Test plan
- Single HEART on req[0], idle: `ack[0]` cycle 1, `collectible_type`=3 cycle 2 only, 0 for cycles 3-4.
- All four requesters CURSE/HEART/POWERUP/HEART same cycle, `rr_ptr`=0: acks 0,1,2,3 on consecutive cycles; outputs 2,3,4,3 spaced 3 cycles.
- Six simultaneous holds, FIFO_DEPTH=4, `tick_en`=0: 4 acks, `fifo_full`=1, rest wait; raise `tick_en` -> remaining acked as space frees, no loss.
- `power_up_active`=1, queue POWERUP, CURSE, HEART: output only 3; `dropped_count`=2.
- Invalid type 7 on req[1]: acked, no output, `dropped_count`=1; 300 drops -> saturates 255.
- Assert `reset_n`=0 during GAP with 3 queued: outputs 0 immediately, `busy`=0, no effects after release.

Source files
------------

// File: rtl/collectible_pkg.sv
// Shared type codes, widths and helpers for the collectible event scheduler.
package collectible_pkg;

    localparam int TYPE_W = 3;

    localparam logic [TYPE_W-1:0] TYPE_NONE    = 3'd0;
    localparam logic [TYPE_W-1:0] TYPE_CURSE   = 3'd2;
    localparam logic [TYPE_W-1:0] TYPE_HEART   = 3'd3;
    localparam logic [TYPE_W-1:0] TYPE_POWERUP = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } sched_state_e;

    function automatic logic is_valid_type(input logic [TYPE_W-1:0] code);
        logic valid;
        case (code)
            TYPE_CURSE:   valid = 1'b1;
            TYPE_HEART:   valid = 1'b1;
            TYPE_POWERUP: valid = 1'b1;
            default:      valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/collectible_event_scheduler_if.sv
// Request/grant bundle between the pickup detectors and the scheduler.
interface collectible_event_scheduler_if
    import collectible_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]        req;
    logic [TYPE_W*N_REQ-1:0] req_type;
    logic [N_REQ-1:0]        ack;

    modport master (output req, output req_type, input ack);
    modport slave  (input req, input req_type, output ack);
endinterface

// File: rtl/collectible_fifo.sv
// Synchronous event queue; pointers carry an extra wrap bit to tell full from empty.
module collectible_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset flushes the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/collectible_event_scheduler.sv
// Round-robin pickup arbiter, effect filter and rate-limited issue FSM feeding the energy block.
module collectible_event_scheduler
    import collectible_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               tick_en,
    collectible_event_scheduler_if.slave       req_bus,
    input  logic                               power_up_active,
    input  logic                               curse_active,
    output logic [TYPE_W-1:0]                  collectible_type,
    output logic                               energy_en,
    output logic                               fifo_full,
    output logic                               busy,
    output logic [7:0]                         dropped_count
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    sched_state_e      state_r;
    logic [GAP_W-1:0]  gap_r;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [N_REQ-1:0]  ack_r;
    logic [TYPE_W-1:0] type_r;
    logic              energy_en_r;
    logic [7:0]        dropped_r;

    logic [TYPE_W-1:0] req_type_s [N_REQ];
    logic [N_REQ-1:0]  avail_s;
    logic [PTR_W-1:0]  cand_s;
    logic [PTR_W-1:0]  winner_s;
    logic              found_s;
    logic              grant_s;
    logic [N_REQ-1:0]  ack_next_s;
    logic [PTR_W-1:0]  rr_next_s;
    logic [TYPE_W-1:0] win_type_s;
    logic              push_s;
    logic              invalid_drop_s;
    logic              pop_s;
    logic              filter_s;
    logic [1:0]        drop_inc_s;
    logic [8:0]        drop_sum_s;
    logic [7:0]        dropped_next_s;
    logic [TYPE_W-1:0] head_s;
    logic              full_s;
    logic              empty_s;
    logic              status_unused_s;

    // Curse status does not gate issue: repeated curses are harmless to the energy block.
    assign status_unused_s = curse_active;

    // Unpack the flat per-requester type bus.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            req_type_s[k] = req_bus.req_type[k*TYPE_W +: TYPE_W];
        end
    end

    // Round-robin search from rr_ptr; requests already being acked are masked out.
    always_comb begin
        avail_s  = req_bus.req & ~ack_r;
        found_s  = 1'b0;
        winner_s = '0;
        cand_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s   = PTR_W'((int'(rr_ptr_r) + k) % N_REQ);
            winner_s = (avail_s[cand_s] && !found_s) ? cand_s : winner_s;
            found_s  = found_s | avail_s[cand_s];
        end
        grant_s        = found_s && !full_s;
        ack_next_s     = grant_s ? (N_REQ'(1) << winner_s) : '0;
        rr_next_s      = PTR_W'((int'(winner_s) + 1) % N_REQ);
        win_type_s     = req_type_s[winner_s];
        push_s         = grant_s && is_valid_type(win_type_s);
        invalid_drop_s = grant_s && !is_valid_type(win_type_s);
    end

    // Pop decision, effect filter and saturating drop accounting.
    always_comb begin
        pop_s          = (state_r == ST_IDLE) && tick_en && !empty_s;
        filter_s       = power_up_active && ((head_s == TYPE_POWERUP) || (head_s == TYPE_CURSE));
        drop_inc_s     = {1'b0, invalid_drop_s} + {1'b0, pop_s && filter_s};
        drop_sum_s     = {1'b0, dropped_r} + {7'd0, drop_inc_s};
        dropped_next_s = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    end

    collectible_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TYPE_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (win_type_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Arbiter state, issue FSM and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            gap_r       <= '0;
            rr_ptr_r    <= '0;
            ack_r       <= '0;
            type_r      <= TYPE_NONE;
            energy_en_r <= 1'b0;
            dropped_r   <= 8'd0;
        end else begin
            energy_en_r <= tick_en;
            ack_r       <= ack_next_s;
            dropped_r   <= dropped_next_s;
            if (grant_s) begin
                rr_ptr_r <= rr_next_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s && !filter_s) begin
                        type_r  <= head_s;
                        gap_r   <= GAP_W'(GAP_CYCLES);
                        state_r <= ST_GAP;
                    end else begin
                        type_r  <= TYPE_NONE;
                    end
                end
                ST_GAP: begin
                    type_r <= TYPE_NONE;
                    // Leaving on the last count keeps issue spacing at GAP_CYCLES+1.
                    if (tick_en) begin
                        if (gap_r <= GAP_W'(1)) begin
                            state_r <= ST_IDLE;
                        end else begin
                            gap_r <= gap_r - GAP_W'(1);
                        end
                    end
                end
                default: begin
                    type_r  <= TYPE_NONE;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_bus.ack      = ack_r;
    assign collectible_type = type_r;
    assign energy_en        = energy_en_r;
    assign dropped_count    = dropped_r;
    assign fifo_full        = full_s;
    assign busy             = !empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_collectible_event_scheduler.sv
// Scoreboard bench: expected acks and effects queued at stimulus time, matched on DUT output.
module tb_collectible_event_scheduler;
    localparam int N = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_en = 1'b0;
    logic       power_up_active = 1'b0;
    logic       curse_active = 1'b0;
    logic [2:0] collectible_type;
    logic       energy_en;
    logic       fifo_full;
    logic       busy;
    logic [7:0] dropped_count;

    collectible_event_scheduler_if #(.N_REQ(N)) bus ();

    collectible_event_scheduler #(
        .N_REQ      (N),
        .FIFO_DEPTH (4),
        .GAP_CYCLES (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .tick_en          (tick_en),
        .req_bus          (bus),
        .power_up_active  (power_up_active),
        .curse_active     (curse_active),
        .collectible_type (collectible_type),
        .energy_en        (energy_en),
        .fifo_full        (fifo_full),
        .busy             (busy),
        .dropped_count    (dropped_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_out_cyc = -1;
    int t0 = 0;
    bit flood = 1'b0;
    bit seen = 1'b0;
    int ack_q [$];
    int exp_q [$];
    int out_cycs [$];

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One cycle: sample at negedge, score acks/effects, retire acked requests.
    task automatic tick();
        logic [N-1:0] exp_ack;
        @(negedge clk);
        cyc++;
        if (reset_n) begin
            if (bus.ack != '0) begin
                if (!flood) begin
                    if (ack_q.size() == 0) begin
                        check_value("ack_unexpected", 32'(bus.ack), 32'd0);
                    end else begin
                        exp_ack = N'(1) << ack_q.pop_front();
                        check_value("ack", 32'(bus.ack), 32'(exp_ack));
                    end
                    bus.req = bus.req & ~bus.ack;
                end
            end
            if (collectible_type != 3'd0) begin
                if (exp_q.size() == 0) begin
                    check_value("out_unexpected", 32'(collectible_type), 32'd0);
                end else begin
                    check_value("out", 32'(collectible_type), 32'(exp_q.pop_front()));
                end
                if (last_out_cyc >= 0) begin
                    check_value("spacing_ge3", 32'((cyc - last_out_cyc) >= 3), 32'd1);
                end
                last_out_cyc = cyc;
                out_cycs.push_back(cyc);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        tick_en = 1'b0;
        power_up_active = 1'b0;
        bus.req = '0;
        bus.req_type = '0;
        ack_q.delete();
        exp_q.delete();
        out_cycs.delete();
        last_out_cyc = -1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_req(input int idx, input logic [2:0] code);
        bus.req[idx] = 1'b1;
        bus.req_type[idx*3 +: 3] = code;
    endtask

    task automatic drained(input string tag);
        check_value({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        check_value({tag, "_ack_left"}, 32'(ack_q.size()), 32'd0);
        check_value({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bus.req = '0;
        bus.req_type = '0;
        #12;
        check_value("rst_ack", 32'(bus.ack), 32'd0);
        check_value("rst_type", 32'(collectible_type), 32'd0);
        check_value("rst_energy_en", 32'(energy_en), 32'd0);
        check_value("rst_full", 32'(fifo_full), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_dropped", 32'(dropped_count), 32'd0);

        // Single HEART: ack at +1, effect at +2 only.
        do_reset();
        tick_en = 1'b1;
        tick();
        check_value("energy_en_on", 32'(energy_en), 32'd1);
        set_req(0, 3'd3);
        ack_q.push_back(0);
        exp_q.push_back(3);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) check_value("t1_ack_c1", 32'(bus.ack), 32'd1);
            if (k == 2) check_value("t1_type_c2", 32'(collectible_type), 32'd3);
            if (k >= 3) check_value("t1_type_zero", 32'(collectible_type), 32'd0);
        end
        tick_en = 1'b0;
        tick();
        check_value("energy_en_off", 32'(energy_en), 32'd0);
        drained("t1");

        // Four simultaneous requests: acks 0..3, effects 2,3,4,3 exactly 3 apart.
        do_reset();
        tick_en = 1'b1;
        set_req(0, 3'd2);
        set_req(1, 3'd3);
        set_req(2, 3'd4);
        set_req(3, 3'd3);
        for (int i = 0; i < 4; i++) ack_q.push_back(i);
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(3);
        run(16);
        check_value("t2_n_out", 32'(out_cycs.size()), 32'd4);
        for (int i = 1; i < out_cycs.size(); i++) begin
            check_value("t2_gap", 32'(out_cycs[i] - out_cycs[i-1]), 32'd3);
        end
        drained("t2");

        // Six holds with tick_en low: four fit, two wait, nothing lost.
        do_reset();
        set_req(0, 3'd3); set_req(1, 3'd2); set_req(2, 3'd3);
        set_req(3, 3'd4); set_req(4, 3'd3); set_req(5, 3'd2);
        for (int i = 0; i < 6; i++) ack_q.push_back(i);
        exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(4); exp_q.push_back(3); exp_q.push_back(2);
        run(8);
        check_value("t3_full", 32'(fifo_full), 32'd1);
        check_value("t3_waiting", 32'(bus.req), 32'h30);
        check_value("t3_no_out", 32'(out_cycs.size()), 32'd0);
        tick_en = 1'b1;
        run(30);
        check_value("t3_n_out", 32'(out_cycs.size()), 32'd6);
        check_value("t3_req_clear", 32'(bus.req), 32'd0);
        drained("t3");

        // Power-up active: POWERUP and CURSE discarded, HEART issued.
        do_reset();
        power_up_active = 1'b1;
        tick_en = 1'b1;
        set_req(0, 3'd4); set_req(1, 3'd2); set_req(2, 3'd3);
        for (int i = 0; i < 3; i++) ack_q.push_back(i);
        exp_q.push_back(3);
        run(10);
        check_value("t4_dropped", 32'(dropped_count), 32'd2);
        check_value("t4_n_out", 32'(out_cycs.size()), 32'd1);
        drained("t4");

        // Invalid code: acked, no effect, one drop; then flood to saturation.
        do_reset();
        tick_en = 1'b1;
        set_req(1, 3'd7);
        ack_q.push_back(1);
        run(5);
        check_value("t5_dropped1", 32'(dropped_count), 32'd1);
        check_value("t5_no_out", 32'(out_cycs.size()), 32'd0);
        flood = 1'b1;
        bus.req_type = '1;
        bus.req = '1;
        run(50);
        check_value("t5_dropped51", 32'(dropped_count), 32'd51);
        run(300);
        check_value("t5_saturated", 32'(dropped_count), 32'd255);
        bus.req = '0;
        flood = 1'b0;
        run(3);
        check_value("t5_still_sat", 32'(dropped_count), 32'd255);
        check_value("t5_no_out2", 32'(out_cycs.size()), 32'd0);

        // Reset during GAP with three queued: everything cleared, nothing issued after.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 3'd3);
            ack_q.push_back(i);
        end
        run(6);
        check_value("t6_full", 32'(fifo_full), 32'd1);
        tick_en = 1'b1;
        exp_q.push_back(3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = (collectible_type != 3'd0);
        end
        check_value("t6_issued", 32'(seen), 32'd1);
        reset_n = 1'b0;
        #1;
        check_value("t6_rst_type", 32'(collectible_type), 32'd0);
        check_value("t6_rst_busy", 32'(busy), 32'd0);
        check_value("t6_rst_full", 32'(fifo_full), 32'd0);
        check_value("t6_rst_ack", 32'(bus.ack), 32'd0);
        #2;
        reset_n = 1'b1;
        run(15);
        check_value("t6_n_out", 32'(out_cycs.size()), 32'd1);
        drained("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
